// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan
// Description : N-channel, W-bit registered multiplexer. Runs either as a
//               manually selected mux or as an auto-scanning round-robin
//               selector that dwells DWELL cycles on each enabled channel.
//               All outputs are registered.
//
// Build option: MUX_SCAN_AUTO_EN
//               defined   -> SCAN state, dwell counter and wrap pulse built
//               undefined -> manual-only; mode is ignored, wrap is tied to 0
//
// Parameters  : N     number of input channels (2..64)
//               W     data width per channel (1..32)
//               DWELL cycles spent on each channel in auto mode (1..255)
//
// Ports       : clk      in   rising-edge clock
//               reset_n  in   synchronous active-low reset
//               d        in   flattened channel data, channel k at d[k*W +: W]
//               s        in   manual channel select
//               mode     in   0 = manual, 1 = auto-scan
//               en_mask  in   per-channel enable, bit k selects channel k
//               y        out  selected channel data
//               ch       out  index of the channel currently driving y
//               valid    out  y carries data from a legal, enabled channel
//               wrap     out  one-cycle pulse when the scan wraps past the
//                             highest enabled index
//
// Revision    : 1.0  initial release
// ============================================================================
module mux_scan #(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N*W-1:0]         d,
    input  logic [$clog2(N)-1:0]   s,
    input  logic                   mode,
    input  logic [N-1:0]           en_mask,
    output logic [W-1:0]           y,
    output logic [$clog2(N)-1:0]   ch,
    output logic                   valid,
    output logic                   wrap
);

    localparam int SW = $clog2(N);

    logic [W-1:0]  r_y;
    logic [SW-1:0] r_ch;
    logic          r_valid;

    // Manual path: s may exceed N-1 when N is not a power of two, so the
    // select is decoded against legal indices only; an illegal s never matches.
    logic [W-1:0]  w_man_y;
    logic          w_man_ok;

    always_comb begin
        w_man_y  = '0;
        w_man_ok = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (s == SW'(k)) begin
                w_man_y  = d[k*W +: W];
                w_man_ok = en_mask[k];
            end
        end
    end

    assign y     = r_y;
    assign ch    = r_ch;
    assign valid = r_valid;

`ifdef MUX_SCAN_AUTO_EN

    localparam int            CW          = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] c_cnt_last  = CW'(DWELL - 1);
    localparam logic [0:0]    c_st_man    = 1'b0;
    localparam logic [0:0]    c_st_scan   = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wrap;

    // Current channel status and data
    logic          w_cur_en;
    logic [W-1:0]  w_cur_y;

    always_comb begin
        w_cur_en = 1'b0;
        w_cur_y  = '0;
        for (int k = 0; k < N; k++) begin
            if (r_ch == SW'(k)) begin
                w_cur_en = en_mask[k];
                w_cur_y  = d[k*W +: W];
            end
        end
    end

    // Cyclic search for the next enabled index above r_ch. A ch left >= N by
    // the manual path is treated as sitting on N-1, so the search starts at 0
    // and counts as a wrap. Offset N lands back on the start index, which is
    // how a single enabled channel advances onto itself with a wrap.
    logic [SW-1:0] w_nxt_ch;
    logic          w_nxt_wrap;
    logic          w_found;
    logic          w_pos_wrap;
    int            w_start;
    int            w_pos;

    always_comb begin
        w_nxt_ch   = r_ch;
        w_nxt_wrap = 1'b0;
        w_found    = 1'b0;
        w_pos_wrap = 1'b0;
        w_pos      = 0;
        w_start    = (int'(r_ch) < N) ? int'(r_ch) : (N - 1);
        for (int i = 1; i <= N; i++) begin
            w_pos      = w_start + i;
            w_pos_wrap = 1'b0;
            if (w_pos >= N) begin
                w_pos      = w_pos - N;
                w_pos_wrap = 1'b1;
            end
            if (!w_found && en_mask[w_pos[SW-1:0]]) begin
                w_found    = 1'b1;
                w_nxt_ch   = w_pos[SW-1:0];
                w_nxt_wrap = w_pos_wrap;
            end
        end
    end

    logic [W-1:0] w_nxt_y;

    always_comb begin
        w_nxt_y = '0;
        for (int k = 0; k < N; k++) begin
            if (w_nxt_ch == SW'(k)) begin
                w_nxt_y = d[k*W +: W];
            end
        end
    end

    // Next-state values for an edge spent in (or entering) SCAN. On the
    // entry edge r_state is still MAN: an enabled channel is held with the
    // counter at zero, even when DWELL = 1.
    logic [SW-1:0] w_sc_ch;
    logic [CW-1:0] w_sc_cnt;
    logic [W-1:0]  w_sc_y;
    logic          w_sc_valid;
    logic          w_sc_wrap;

    always_comb begin
        w_sc_ch    = r_ch;
        w_sc_cnt   = '0;
        w_sc_y     = '0;
        w_sc_valid = 1'b0;
        w_sc_wrap  = 1'b0;
        if (en_mask == '0) begin
            // nothing selectable: hold ch, outputs quiet
        end else if (!w_cur_en || (r_state == c_st_scan && r_cnt == c_cnt_last)) begin
            w_sc_ch    = w_nxt_ch;
            w_sc_y     = w_nxt_y;
            w_sc_valid = 1'b1;
            w_sc_wrap  = w_nxt_wrap;
        end else begin
            w_sc_y     = w_cur_y;
            w_sc_valid = 1'b1;
            w_sc_cnt   = (r_state == c_st_scan) ? (r_cnt + 1'b1) : '0;
        end
    end

    // mode selects the target state; the target state's action is applied on
    // the same edge that samples mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_man;
            r_cnt   <= '0;
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (mode) begin
            r_state <= c_st_scan;
            r_cnt   <= w_sc_cnt;
            r_y     <= w_sc_y;
            r_ch    <= w_sc_ch;
            r_valid <= w_sc_valid;
            r_wrap  <= w_sc_wrap;
        end else begin
            r_state <= c_st_man;
            r_cnt   <= '0;
            r_y     <= w_man_ok ? w_man_y : '0;
            r_ch    <= s;
            r_valid <= w_man_ok;
            r_wrap  <= 1'b0;
        end
    end

    assign wrap = r_wrap;

`else

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_man_ok ? w_man_y : '0;
            r_ch    <= s;
            r_valid <= w_man_ok;
        end
    end

    assign wrap = 1'b0;

    // mode and DWELL have no function in the manual-only build
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, mode, DWELL[0]};

`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan
// Description : Self-checking bench for mux_scan (N=8, W=4, DWELL=3).
//               Directed vectors push expected outputs into a queue; a
//               monitor pops one entry per clock and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan;

    localparam int N     = 8;
    localparam int W     = 4;
    localparam int DWELL = 3;

    logic          clk;
    logic          reset_n;
    logic [N*W-1:0] d;
    logic [2:0]    s;
    logic          mode;
    logic [N-1:0]  en_mask;
    logic [W-1:0]  y;
    logic [2:0]    ch;
    logic          valid;
    logic          wrap;

    mux_scan #(.N(N), .W(W), .DWELL(DWELL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .s       (s),
        .mode    (mode),
        .en_mask (en_mask),
        .y       (y),
        .ch      (ch),
        .valid   (valid),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] y;
        logic [2:0] ch;
        logic       v;
        logic       w;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

    // Expected channel sequence for DWELL=3 over mask 1010_0101
    int scan_seq [13] = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 7, 7, 7, 0};

    // Issue one clock of stimulus (inputs already set) and its expectation
    task automatic step(input string nm, input logic [3:0] ey, input logic [2:0] ech,
                        input logic ev, input logic ew);
        exp_t e;
        e.y  = ey;
        e.ch = ech;
        e.v  = ev;
        e.w  = ew;
        q.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge
    always begin
        exp_t  e;
        string nm;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            checks++;
            if (y !== e.y || ch !== e.ch || valid !== e.v || wrap !== e.w) begin
                errors++;
                $display("FAIL %s: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                         nm, y, ch, valid, wrap, e.y, e.ch, e.v, e.w);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        d       = '1;
        s       = 3'd5;
        mode    = 1'b1;
        en_mask = 8'hFF;
        @(negedge clk);

        // Reset overrides mode and live data
        step("reset0", 4'h0, 3'd0, 1'b0, 1'b0);
        step("reset1", 4'h0, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        s       = 3'd0;
        step("post_reset", 4'hF, 3'd0, 1'b1, 1'b0);

        // Manual sweep, d[k] = k+1
        d    = 32'h8765_4321;
        mode = 1'b0;
        for (int k = 0; k < N; k++) begin
            s = 3'(k);
            step("man_sweep", 4'(k + 1), 3'(k), 1'b1, 1'b0);
        end
        en_mask = 8'hF7;
        s       = 3'd3;
        step("man_disabled", 4'h0, 3'd3, 1'b0, 1'b0);

`ifdef MUX_SCAN_AUTO_EN
        en_mask = 8'b1010_0101;
        s       = 3'd0;
        step("man_pre_scan", 4'h1, 3'd0, 1'b1, 1'b0);

        mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step("scan_seq", 4'(scan_seq[i] + 1), 3'(scan_seq[i]), 1'b1, (i == 12));
        end
        step("scan_c1", 4'h1, 3'd0, 1'b1, 1'b0);
        step("scan_c2", 4'h1, 3'd0, 1'b1, 1'b0);
        step("scan_ch2", 4'h3, 3'd2, 1'b1, 1'b0);
        step("scan_ch2_c1", 4'h3, 3'd2, 1'b1, 1'b0);

        // Drop channel 2 mid-dwell
        en_mask = 8'b1010_0001;
        step("mask_drop", 4'h6, 3'd5, 1'b1, 1'b0);
        step("mask_drop_hold", 4'h6, 3'd5, 1'b1, 1'b0);

        // Empty mask freezes ch
        en_mask = 8'h00;
        step("empty0", 4'h0, 3'd5, 1'b0, 1'b0);
        step("empty1", 4'h0, 3'd5, 1'b0, 1'b0);

        // Restore a single channel above-and-around: search wraps to 4
        en_mask = 8'h10;
        step("restore", 4'h5, 3'd4, 1'b1, 1'b1);
        d[19:16] = 4'hA;
        step("live_data", 4'hA, 3'd4, 1'b1, 1'b0);
        d[19:16] = 4'h5;
        step("single_c2", 4'h5, 3'd4, 1'b1, 1'b0);
        step("single_wrap", 4'h5, 3'd4, 1'b1, 1'b1);

        en_mask = 8'h20;
        step("to_ch5", 4'h6, 3'd5, 1'b1, 1'b0);

        // Back to manual
        mode    = 1'b0;
        en_mask = 8'hFF;
        s       = 3'd1;
        step("mode_switch", 4'h2, 3'd1, 1'b1, 1'b0);

        // Entry keeps an enabled ch, then reset mid-dwell
        mode = 1'b1;
        step("scan_entry", 4'h2, 3'd1, 1'b1, 1'b0);
        reset_n = 1'b0;
        step("reset_mid", 4'h0, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step("reset_reentry", 4'h1, 3'd0, 1'b1, 1'b0);
`else
        // Manual-only build: mode is ignored
        en_mask = 8'hFF;
        mode    = 1'b1;
        s       = 3'd6;
        step("man_mode1_s6", 4'h7, 3'd6, 1'b1, 1'b0);
        s = 3'd2;
        for (int i = 0; i < 4; i++) begin
            step("man_mode1_s2", 4'h3, 3'd2, 1'b1, 1'b0);
        end
        s = 3'd7;
        step("man_mode1_s7", 4'h8, 3'd7, 1'b1, 1'b0);
`endif

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
